// File: rtl/store_buf_pkg.sv
// Shared types and constants for the store commit buffer.
// The optional load-forwarding port set is enabled with the STORE_FWD_EN macro.
package store_buf_pkg;

    localparam logic [2:0] WIDTH_SB = 3'b000;
    localparam logic [2:0] WIDTH_SH = 3'b001;
    localparam logic [2:0] WIDTH_SW = 3'b010;

    // Entries hold tags up to this width; narrower ROB tags are zero-extended.
    localparam int ENTRY_TAG_W = 16;

    localparam int ERR_TAG   = 0;
    localparam int ERR_ALIGN = 1;

    typedef struct packed {
        logic [ENTRY_TAG_W-1:0] tag;
        logic [31:0]            addr;
        logic [31:0]            data;
        logic [3:0]             be;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/store_be_gen.sv
// Byte-enable and lane-data formatter for a single store.
// Misaligned or invalid-width stores produce be=0000 and raise misaligned.
module store_be_gen
    import store_buf_pkg::*;
(
    input  logic [2:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b0000;
        lane_data  = data;
        misaligned = 1'b0;
        case (width)
            WIDTH_SB: begin
                be        = 4'b0001 << addr_lo;
                lane_data = {4{data[7:0]}};
            end
            WIDTH_SH: begin
                if (addr_lo[0]) begin
                    misaligned = 1'b1;
                end else begin
                    be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                    lane_data = {2{data[15:0]}};
                end
            end
            WIDTH_SW: begin
                if (addr_lo != 2'b00) misaligned = 1'b1;
                else                  be = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_commit_buffer.sv
// In-order store buffer: holds executed stores until ROB commit, then drains them to memory.
// Define STORE_FWD_EN to add the combinational load-forwarding ports.
module store_commit_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     exe_valid,
    input  logic [TAG_W-1:0]         exe_tag,
    input  logic [31:0]              exe_addr,
    input  logic [31:0]              exe_data,
    input  logic [2:0]               exe_width,
    output logic                     exe_ready,
    input  logic                     commit_valid,
    input  logic [TAG_W-1:0]         commit_tag,
    input  logic                     flush,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
`ifdef STORE_FWD_EN
    input  logic [31:0]              ld_addr,
    output logic                     fwd_hit,
    output logic [31:0]              fwd_data,
    output logic                     fwd_conflict,
`endif
    output logic [1:0]               err
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

    logic [PTR_W-1:0] head, cptr, tail, occ, cptr_inc;
    entry_t           buf_q [DEPTH];
    drain_state_t     state, state_next;

    logic [3:0]             gen_be;
    logic [31:0]            gen_data;
    logic                   gen_mis;
    logic                   push, has_spec, do_commit, tag_bad, load, pop;
    logic [ENTRY_TAG_W-1:0] commit_tag_ext;

    store_be_gen u_be_gen (
        .width      (exe_width),
        .addr_lo    (exe_addr[1:0]),
        .data       (exe_data),
        .be         (gen_be),
        .lane_data  (gen_data),
        .misaligned (gen_mis)
    );

    assign occ            = tail - head;
    assign count          = occ;
    assign exe_ready      = (occ != FULL);
    assign push           = exe_valid && exe_ready && !flush;
    assign has_spec       = (cptr != tail);
    assign do_commit      = commit_valid && has_spec;
    assign commit_tag_ext = ENTRY_TAG_W'(commit_tag);
    assign tag_bad        = commit_valid &&
                            (!has_spec || (buf_q[cptr[IDX_W-1:0]].tag != commit_tag_ext));
    assign cptr_inc       = cptr + {{(PTR_W-1){1'b0}}, do_commit};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Unwritable (be=0000) entries retire straight from IDLE without a request.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (head != cptr) begin
                    if (buf_q[head[IDX_W-1:0]].be == 4'b0000) begin
                        pop = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            cptr      <= '0;
            tail      <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            err       <= 2'b00;
        end else begin
            if (pop) head <= head + ONE;
            cptr <= cptr_inc;
            if (flush)     tail <= cptr_inc;
            else if (push) tail <= tail + ONE;
            if (load) begin
                mem_req   <= 1'b1;
                mem_addr  <= buf_q[head[IDX_W-1:0]].addr;
                mem_wdata <= buf_q[head[IDX_W-1:0]].data;
                mem_be    <= buf_q[head[IDX_W-1:0]].be;
            end else if (state == REQ && mem_ack) begin
                mem_req <= 1'b0;
            end
            if (tag_bad)        err[ERR_TAG]   <= 1'b1;
            if (push && gen_mis) err[ERR_ALIGN] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[tail[IDX_W-1:0]] <= '{tag:  ENTRY_TAG_W'(exe_tag),
                                        addr: {exe_addr[31:2], 2'b00},
                                        data: gen_data,
                                        be:   gen_be};
        end
    end

`ifdef STORE_FWD_EN
    logic [IDX_W-1:0] fwd_idx;
    logic [1:0]       unused_ld_lo;

    assign unused_ld_lo = ld_addr[1:0];

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwd_hit      = 1'b0;
        fwd_data     = '0;
        fwd_conflict = 1'b0;
        fwd_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head[IDX_W-1:0] + IDX_W'(i);
            if (PTR_W'(i) < occ &&
                buf_q[fwd_idx].addr[31:2] == ld_addr[31:2] &&
                buf_q[fwd_idx].be != 4'b0000) begin
                if (buf_q[fwd_idx].be == 4'b1111) begin
                    fwd_hit  = 1'b1;
                    fwd_data = buf_q[fwd_idx].data;
                end else begin
                    fwd_hit      = 1'b0;
                    fwd_data     = '0;
                    fwd_conflict = 1'b1;
                end
            end
        end
        if (fwd_conflict) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed self-checking bench for store_commit_buffer (default build, DEPTH=4, TAG_W=6).
module tb_store_commit_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exe_valid = 1'b0;
    logic [5:0]  exe_tag = '0;
    logic [31:0] exe_addr = '0;
    logic [31:0] exe_data = '0;
    logic [2:0]  exe_width = '0;
    logic        exe_ready;
    logic        commit_valid = 1'b0;
    logic [5:0]  commit_tag = '0;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [2:0]  count;
    logic [1:0]  err;

    int errors = 0;
    int checks = 0;

    store_commit_buffer #(.DEPTH(4), .TAG_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .exe_valid    (exe_valid),
        .exe_tag      (exe_tag),
        .exe_addr     (exe_addr),
        .exe_data     (exe_data),
        .exe_width    (exe_width),
        .exe_ready    (exe_ready),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .flush        (flush),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_ack      (mem_ack),
        .count        (count),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] tag, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] width);
        exe_valid = 1'b1;
        exe_tag   = tag;
        exe_addr  = addr;
        exe_data  = data;
        exe_width = width;
        step();
        exe_valid = 1'b0;
    endtask

    task automatic commit(input logic [5:0] tag);
        commit_valid = 1'b1;
        commit_tag   = tag;
        step();
        commit_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (mem_req === 1'b1) break;
            step();
        end
        check(tag, 72'(mem_req), 72'(1'b1));
    endtask

    task automatic ack();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step();
        step();
        check("rst_count", 72'(count), 72'(0));
        check("rst_ready", 72'(exe_ready), 72'(1));
        check("rst_req", 72'(mem_req), 72'(0));
        check("rst_addr", 72'(mem_addr), 72'(0));
        check("rst_wdata", 72'(mem_wdata), 72'(0));
        check("rst_be", 72'(mem_be), 72'(0));
        check("rst_err", 72'(err), 72'(0));
        reset = 1'b0;
        step();

        // 1: single SW store
        push(6'd5, 32'h100, 32'hDEADBEEF, 3'b010);
        check("t1_count_push", 72'(count), 72'(1));
        check("t1_no_req_spec", 72'(mem_req), 72'(0));
        commit(6'd5);
        wait_req("t1_req");
        check("t1_addr", 72'(mem_addr), 72'(32'h100));
        check("t1_wdata", 72'(mem_wdata), 72'(32'hDEADBEEF));
        check("t1_be", 72'(mem_be), 72'(4'b1111));
        ack();
        check("t1_req_drop", 72'(mem_req), 72'(0));
        check("t1_count", 72'(count), 72'(0));

        // 2: SB then SH, drained in order
        push(6'd1, 32'h203, 32'h0000007A, 3'b000);
        push(6'd2, 32'h202, 32'h00001234, 3'b001);
        commit(6'd1);
        commit(6'd2);
        wait_req("t2_req_a");
        check("t2_addr_a", 72'(mem_addr), 72'(32'h200));
        check("t2_wdata_a", 72'(mem_wdata), 72'(32'h7A7A7A7A));
        check("t2_be_a", 72'(mem_be), 72'(4'b1000));
        ack();
        check("t2_idle_gap", 72'(mem_req), 72'(0));
        wait_req("t2_req_b");
        check("t2_addr_b", 72'(mem_addr), 72'(32'h200));
        check("t2_wdata_b", 72'(mem_wdata), 72'(32'h12341234));
        check("t2_be_b", 72'(mem_be), 72'(4'b1100));
        ack();
        check("t2_count", 72'(count), 72'(0));
        check("t2_err", 72'(err), 72'(0));

        // 3: fill, reject push while full, commit two with flush on the second
        push(6'd10, 32'h300, 32'h1, 3'b010);
        push(6'd11, 32'h304, 32'h2, 3'b010);
        push(6'd12, 32'h308, 32'h3, 3'b010);
        push(6'd13, 32'h30C, 32'h4, 3'b010);
        check("t3_full_count", 72'(count), 72'(4));
        check("t3_full_ready", 72'(exe_ready), 72'(0));
        push(6'd14, 32'h310, 32'h5, 3'b010);
        check("t3_full_hold", 72'(count), 72'(4));
        commit(6'd10);
        commit_valid = 1'b1;
        commit_tag   = 6'd11;
        flush        = 1'b1;
        step();
        commit_valid = 1'b0;
        flush        = 1'b0;
        check("t3_flush_count", 72'(count), 72'(2));
        check("t3_flush_ready", 72'(exe_ready), 72'(1));
        wait_req("t3_req_a");
        check("t3_addr_a", 72'(mem_addr), 72'(32'h300));
        check("t3_wdata_a", 72'(mem_wdata), 72'(32'h1));
        ack();
        wait_req("t3_req_b");
        check("t3_addr_b", 72'(mem_addr), 72'(32'h304));
        check("t3_wdata_b", 72'(mem_wdata), 72'(32'h2));
        ack();
        for (int i = 0; i < 5; i++) step();
        check("t3_no_third", 72'(mem_req), 72'(0));
        check("t3_count", 72'(count), 72'(0));
        check("t3_err", 72'(err), 72'(0));

        // 4: tag mismatch is sticky, store still drains
        push(6'd3, 32'h400, 32'hCAFEF00D, 3'b010);
        commit(6'd9);
        check("t4_err_tag", 72'(err), 72'(2'b01));
        wait_req("t4_req");
        check("t4_addr", 72'(mem_addr), 72'(32'h400));
        check("t4_wdata", 72'(mem_wdata), 72'(32'hCAFEF00D));
        ack();
        check("t4_count", 72'(count), 72'(0));
        check("t4_err_sticky", 72'(err), 72'(2'b01));

        // 5: misaligned SW pops in one cycle without a request
        push(6'd4, 32'h102, 32'h55667788, 3'b010);
        check("t5_err_align", 72'(err), 72'(2'b11));
        commit(6'd4);
        check("t5_count_commit", 72'(count), 72'(1));
        step();
        check("t5_count_pop", 72'(count), 72'(0));
        check("t5_no_req", 72'(mem_req), 72'(0));

        // 6: stall with mem_ack low, then reset mid-request
        push(6'd20, 32'h500, 32'h11223344, 3'b010);
        commit(6'd20);
        wait_req("t6_req");
        for (int i = 0; i < 10; i++) begin
            step();
            check("t6_hold", {3'b0, mem_req, mem_be, mem_addr, mem_wdata},
                  {3'b0, 1'b1, 4'b1111, 32'h500, 32'h11223344});
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_req", 72'(mem_req), 72'(0));
        check("t6_rst_count", 72'(count), 72'(0));
        check("t6_rst_err", 72'(err), 72'(0));
        check("t6_rst_be", 72'(mem_be), 72'(0));

        // Push dropped by a same-cycle flush; commit with nothing speculative
        exe_valid = 1'b1;
        exe_tag   = 6'd30;
        exe_addr  = 32'h600;
        exe_data  = 32'h99;
        exe_width = 3'b010;
        flush     = 1'b1;
        step();
        exe_valid = 1'b0;
        flush     = 1'b0;
        check("flush_drop_count", 72'(count), 72'(0));
        commit(6'd7);
        check("empty_commit_err", 72'(err), 72'(2'b01));
        check("empty_commit_count", 72'(count), 72'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
